// File: rtl/velocity_cell_ctrl.sv
// velocity_cell_ctrl
//   Streams one cell's particle velocities out of a shared velocity memory.
//   Address 0 holds the cell's particle count N, and addresses 1..N hold the
//   velocities, packed {vz, vy, vx}. Motion-update writes share the same memory
//   port and always take priority over reads.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse that starts a stream (ignored unless idle)
//   stall             consumer hold; no new stream read is issued while high
//   wr_req/addr/data  write request; wr_ack is asserted in the same cycle
//   mem_*             single-port memory interface (mem_q arrives 1 cycle after mem_rden)
//   out_valid/addr/data  one streamed velocity per valid cycle
//   particle_count    clamped count latched from address 0
//   busy, done        busy is high outside IDLE; done is a one-cycle end pulse
//   cnt_err           sticky flag, set when the stored count exceeds PARTICLE_NUM-1
module velocity_cell_ctrl #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  busy,
  output logic                  done,
  output logic                  cnt_err
);

  typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(PARTICLE_NUM - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_nxt;
  logic                  rd_issue, stream_issue, done_nxt;
  logic [ADDR_WIDTH-1:0] cnt_raw, cnt_clamped;
  logic                  cnt_over;

  assign cnt_raw     = mem_q[ADDR_WIDTH-1:0];
  assign cnt_over    = cnt_raw > MAX_ADDR;
  assign cnt_clamped = cnt_over ? MAX_ADDR : cnt_raw;

  always_comb begin
    state_nxt    = state;
    rd_addr_nxt  = rd_addr;
    rd_issue     = 1'b0;
    stream_issue = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        rd_addr_nxt = '0;
        if (start) state_nxt = RD_CNT;
      end
      RD_CNT: begin
        // The count read ignores stall and only waits for the port to be free.
        if (!wr_req) begin
          rd_issue  = 1'b1;
          state_nxt = WAIT_CNT;
        end
      end
      WAIT_CNT: begin
        if (cnt_clamped == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt   = STREAM;
          rd_addr_nxt = ADDR_WIDTH'(1);
        end
      end
      STREAM: begin
        if (!wr_req && !stall) begin
          rd_issue     = 1'b1;
          stream_issue = 1'b1;
          // rd_addr stops at N, which is at most MAX_ADDR, so it never
          // leaves the memory range.
          if (rd_addr == particle_count) state_nxt = DRAIN;
          else rd_addr_nxt = rd_addr + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rd_addr        <= '0;
      out_valid      <= 1'b0;
      out_addr       <= '0;
      particle_count <= '0;
      cnt_err        <= 1'b0;
      done           <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_addr   <= rd_addr_nxt;
      out_valid <= stream_issue;
      done      <= done_nxt;
      if (stream_issue) out_addr <= rd_addr;
      if (state == WAIT_CNT) begin
        particle_count <= cnt_clamped;
        if (cnt_over) cnt_err <= 1'b1;
      end
    end
  end

  // The memory registers its read data, so mem_q is already held steady in the
  // out_valid cycle. It is passed through rather than registered a second time.
  assign out_data = out_valid ? mem_q : '0;

  // The write port wins the shared memory port. Gating by rst_n keeps every
  // output at 0 while reset is asserted.
  assign wr_ack      = rst_n & wr_req;
  assign mem_wren    = rst_n & wr_req;
  assign mem_rden    = rst_n & rd_issue;
  assign mem_address = !rst_n ? '0 : (wr_req ? wr_addr : rd_addr);
  assign mem_data    = (rst_n && wr_req) ? wr_data : '0;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_velocity_cell_ctrl.sv
module tb_velocity_cell_ctrl;
  localparam int DW = 96, AW = 8, PN = 220;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0, wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic wr_ack, mem_rden, mem_wren, out_valid, busy, done, cnt_err;
  logic [AW-1:0] mem_address, out_addr, particle_count;
  logic [DW-1:0] mem_data, out_data;
  logic [DW-1:0] mem_q = '0;

  int n_chk = 0, n_err = 0;

  velocity_cell_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_address(mem_address), .mem_data(mem_data), .mem_rden(mem_rden),
    .mem_wren(mem_wren), .mem_q(mem_q), .out_valid(out_valid),
    .out_data(out_data), .out_addr(out_addr), .particle_count(particle_count),
    .busy(busy), .done(done), .cnt_err(cnt_err));

  always #5 clk = ~clk;

  // Default memory contents: a recognisable pattern per address.
  function automatic logic [DW-1:0] vel(input int i);
    return {32'(i + 32'h300), 32'(i + 32'h200), 32'(i + 32'h100)};
  endfunction

  // Memory model with a registered read port. Unwritten addresses return vel().
  logic [DW-1:0] mem [0:255];
  bit   [255:0]  written;
  always @(posedge clk) begin
    if (mem_rden) mem_q <= written[mem_address] ? mem[mem_address] : vel(int'(mem_address));
    if (mem_wren) begin
      mem[mem_address]     <= mem_data;
      written[mem_address] <= 1'b1;
    end
  end

  // Monitor, sampling on the falling edge. Inputs change just after the rising edge.
  int cyc = 0, done_cnt = 0, both_cnt = 0, ack_cnt = 0;
  int q_addr[$], q_cyc[$];
  logic [DW-1:0] q_data[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (out_valid) begin
      q_addr.push_back(int'(out_addr));
      q_data.push_back(out_data);
      q_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (mem_rden && mem_wren) both_cnt++;
    if (wr_req && wr_ack) ack_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_req = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int c = 0;
    while (done_cnt == d0 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    check({tag, "_timeout"}, (c >= 2000), 0);
    repeat (3) tick();
  endtask

  int base, d0, errs, c;
  logic [DW-1:0] v2, v3;
  bit wr_t[8];
  logic [AW-1:0] wa_t[8];
  bit st_t[8], stall_t[8];

  initial begin
    // Reset state.
    wr_req = 1'b1; wr_addr = 8'h55; wr_data = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_ack", wr_ack, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_addr", mem_address, 0);
    check("rst_busy", busy, 0);
    check("rst_outs", {out_valid, done, cnt_err, mem_rden}, 0);
    check("rst_pcnt", particle_count, 0);
    wr_req = 1'b0;
    rst_n = 1'b1;
    tick();

    // N = 3: three consecutive outputs.
    write(0, 96'd3);
    base = q_addr.size(); d0 = done_cnt;
    pulse_start();
    wait_done("n3", d0);
    check("n3_count", q_addr.size() - base, 3);
    for (int i = 0; i < 3; i++) begin
      check("n3_addr", q_addr[base+i], i + 1);
      check("n3_data", q_data[base+i], vel(i + 1));
    end
    check("n3_consec", q_cyc[base+2] - q_cyc[base], 2);
    check("n3_pcnt", particle_count, 3);
    check("n3_done", done_cnt - d0, 1);
    check("n3_busy", busy, 0);
    check("n3_err", cnt_err, 0);

    // N = 0: no outputs, only done.
    write(0, 96'd0);
    base = q_addr.size(); d0 = done_cnt;
    pulse_start();
    wait_done("n0", d0);
    check("n0_count", q_addr.size() - base, 0);
    check("n0_done", done_cnt - d0, 1);
    check("n0_err", cnt_err, 0);
    check("n0_pcnt", particle_count, 0);

    // N = 250 is clamped to 219.
    write(0, 96'd250);
    base = q_addr.size(); d0 = done_cnt;
    pulse_start();
    wait_done("clamp", d0);
    check("clamp_pcnt", particle_count, 219);
    check("clamp_err", cnt_err, 1);
    check("clamp_count", q_addr.size() - base, 219);
    check("clamp_last", q_addr[q_addr.size()-1], 219);
    check("clamp_lastd", q_data[q_data.size()-1], vel(219));
    errs = 0;
    for (int i = 0; i < 219; i++)
      if (q_addr[base+i] != i + 1 || q_data[base+i] !== vel(i + 1)) errs++;
    check("clamp_order", errs, 0);

    // Reset during STREAM.
    write(0, 96'd10);
    base = q_addr.size(); d0 = done_cnt;
    pulse_start();
    c = 0;
    while (q_addr.size() - base < 2 && c < 100) begin tick(); c++; end
    check("mid_reach", c < 100, 1);
    wr_req = 1'b1; wr_addr = 8'h7; wr_data = '1;
    rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_outs", {out_valid, done, cnt_err, mem_rden, mem_wren, wr_ack}, 0);
    check("mid_pcnt", particle_count, 0);
    check("mid_odata", out_data, 0);
    wr_req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("mid_nodone", done_cnt - d0, 0);

    // N = 4 with writes, a stall, and an ignored start. The write issued together
    // with start goes to address 2, the mid-stream write to address 3 lands
    // before its read, and the write to address 0 must not change the count.
    write(0, 96'd4);
    v2 = {32'hAAAA_0002, 32'hBBBB_0002, 32'hCCCC_0002};
    v3 = {32'hAAAA_0003, 32'hBBBB_0003, 32'hCCCC_0003};
    wr_t    = '{1, 0, 0, 0, 1, 0, 0, 1};
    wa_t    = '{8'd2, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0};
    st_t    = '{1, 0, 0, 0, 1, 0, 0, 0};
    stall_t = '{0, 0, 0, 0, 0, 0, 1, 0};
    base = q_addr.size(); d0 = done_cnt; c = ack_cnt;
    for (int k = 0; k < 8; k++) begin
      wr_req = wr_t[k]; wr_addr = wa_t[k]; start = st_t[k]; stall = stall_t[k];
      wr_data = (wa_t[k] == 8'd2) ? v2 : (wa_t[k] == 8'd3) ? v3 : 96'd99;
      tick();
    end
    wr_req = 1'b0; start = 1'b0; stall = 1'b0;
    wait_done("mix", d0);
    check("mix_acks", ack_cnt - c, 3);
    check("mix_count", q_addr.size() - base, 4);
    for (int i = 0; i < 4; i++) check("mix_addr", q_addr[base+i], i + 1);
    check("mix_d1", q_data[base], vel(1));
    check("mix_d2", q_data[base+1], v2);
    check("mix_d3", q_data[base+2], v3);
    check("mix_d4", q_data[base+3], vel(4));
    check("mix_pcnt", particle_count, 4);
    check("mix_done", done_cnt - d0, 1);
    check("mix_busy", busy, 0);
    check("no_rd_wr_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
